// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory that answers core load/store
// requests after a programmable number of wait states.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses report rsp_err, no write
//   undefined -> misaligned half/word accesses are force-aligned (default)
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words of storage (power of two)
//   WAIT_CYCLES  wait states added to every access (0..15)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   req_valid    request presented by the core
//   req_ready    block can accept a request (only while idle)
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned zero-extend load data
//   req_addr     byte address
//   req_wdata    right-aligned store data
//   rsp_valid    response available
//   rsp_ready    core accepts the response
//   rsp_rdata    extended load data (0 for stores and errors)
//   rsp_err      access fault
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_q, ld_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_ready_q, req_ready_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        hi_bad;
  logic        size_bad;
  logic        mis_bad;
  logic        cur_err;
  logic [1:0]  lane;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [3:0]  be;
  logic        mem_we;

  // Shift the addressed lanes down to bit 0 and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  ln,
                                              input logic        uns);
    logic [31:0] sh;
    sh = word >> {ln, 3'b000};
    case (size)
      2'b00:   load_extend = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'b01:   load_extend = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  assign accept = req_valid & req_ready_q;

  // With zero wait states the access completes on the accept edge itself,
  // so the request fields must come straight from the inputs while idle.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_size  = req_size;
      cur_uns   = req_unsigned;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign enter_resp = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

  always_comb begin
    hi_bad   = |cur_addr[31:AW+2];
    size_bad = (cur_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_bad  = ((cur_size == 2'b01) && cur_addr[0]) ||
               ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
    lane     = cur_addr[1:0];
`else
    mis_bad  = 1'b0;
    case (cur_size)
      2'b01:   lane = {cur_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = cur_addr[1:0];
    endcase
`endif
    cur_err  = hi_bad | size_bad | mis_bad;
  end

  assign idx     = cur_addr[AW+1:2];
  assign rd_word = mem[idx];

  always_comb begin
    case (cur_size)
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_word = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << lane;
        wr_word = {2{cur_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_word = cur_wdata;
      end
    endcase
  end

  // Reset gating keeps a store from committing on an edge held in reset.
  assign mem_we = enter_resp & cur_we & ~cur_err & reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ld_d        = ld_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // First RESP cycle publishes the captured result; it is then held
        // until the core takes it.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_q;
          rsp_err_d   = err_q;
        end else if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      err_d = cur_err;
      ld_d  = (cur_err || cur_we) ? 32'h0
                                  : load_extend(rd_word, cur_size, lane, cur_uns);
    end

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      ld_q        <= 32'h0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ld_q        <= ld_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
